// File: rtl/alu_pkg.sv
// Shared constants for the add/sub datapath.
//   OpAdd / OpSub : funct7_5 encodings selecting add or subtract.
//   signed_max / signed_min : saturation bounds for a given operand width, returned
//   zero-extended to MaxWidth so callers can slice them to their own WIDTH.
package alu_pkg;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

  localparam int unsigned MaxWidth = 128;

  function automatic logic [MaxWidth-1:0] signed_max(input int unsigned width);
    logic [MaxWidth-1:0] v;
    v = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (i < int'(width) - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MaxWidth-1:0] signed_min(input int unsigned width);
    logic [MaxWidth-1:0] v;
    v = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (i == int'(width) - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One BLOCK-bit carry-lookahead group.
//   a, b : operand slices (b already inverted for subtract)
//   cin  : carry into the group
//   sum  : slice sum
//   gen  : group generate (group produces a carry regardless of cin)
//   prop : group propagate (group passes cin through)
module cla_group #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             gen,
  output logic             prop
);

  logic [BLOCK-1:0] g_bit;
  logic [BLOCK-1:0] p_bit;
  logic [BLOCK-1:0] carry;

  always_comb begin
    g_bit    = a & b;
    p_bit    = a ^ b;
    carry    = '0;
    carry[0] = cin;
    // Written as a recurrence; synthesis flattens it into lookahead terms.
    for (int i = 1; i < int'(BLOCK); i++) begin
      carry[i] = g_bit[i-1] | (p_bit[i-1] & carry[i-1]);
    end
    sum  = p_bit ^ carry;
    gen  = 1'b0;
    for (int i = 0; i < int'(BLOCK); i++) begin
      gen = g_bit[i] | (p_bit[i] & gen);
    end
    prop = &p_bit;
  end

endmodule

// File: rtl/pipelined_cla_add_sub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
//   CLK, rst            : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   : operand beat handshake
//   rs_1, rs_2          : operands; funct7_5 selects add (0) or rs_1 - rs_2 (1)
//   En                  : 0 produces an all-zero result beat (zero flag set)
//   sat_en              : clamp to signed max/min on overflow
//   out_valid/out_ready : result beat handshake
//   result, overflow, carry_out, zero, negative : result beat, forced 0 while idle
// The carry chain is cut into STAGES slices; each stage adds its slice of groups
// and registers the slice carry-out, partial sum and remaining operand bits.
module pipelined_cla_add_sub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs_1,
  input  logic [WIDTH-1:0] rs_2,
  input  logic             En,
  input  logic             funct7_5,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry_out,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned GroupsPerStage = (WIDTH / BLOCK) / STAGES;
  localparam int unsigned SliceW         = GroupsPerStage * BLOCK;
  localparam int unsigned Last           = STAGES - 1;

  localparam logic [MaxWidth-1:0] SMaxFull = signed_max(WIDTH);
  localparam logic [MaxWidth-1:0] SMinFull = signed_min(WIDTH);
  localparam logic [WIDTH-1:0]    SMax     = SMaxFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0]    SMin     = SMinFull[WIDTH-1:0];

  // Stage registers
  logic [STAGES-1:0] valid_q, en_q, sat_q, c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  // Per-stage inputs (from ports for stage 0, else from the previous register)
  logic [STAGES-1:0] src_valid, src_en, src_sat, src_c, stage_cout, load;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [WIDTH-1:0]  s_d   [STAGES];
  logic [SliceW-1:0] slice_sum [STAGES];

  always_comb begin
    src_valid[0] = in_valid;
    src_en[0]    = En;
    src_sat[0]   = sat_en;
    // Subtract as a + ~b + 1; the +1 enters as carry-in.
    src_a[0]     = rs_1;
    src_b[0]     = (funct7_5 == OpSub) ? ~rs_2 : rs_2;
    src_c[0]     = (funct7_5 == OpSub);
    src_s[0]     = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_valid[k] = valid_q[k-1];
      src_en[k]    = en_q[k-1];
      src_sat[k]   = sat_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_c[k]     = c_q[k-1];
      src_s[k]     = s_q[k-1];
    end
  end

  // A stage loads when empty or when its occupant moves on this cycle.
  always_comb begin
    logic ready_down;
    load       = '0;
    ready_down = out_ready;
    for (int k = int'(Last); k >= 0; k--) begin
      load[k]    = !valid_q[k] || ready_down;
      ready_down = load[k];
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [GroupsPerStage:0]   gc;
    logic [GroupsPerStage-1:0] gg, gp;

    assign gc[0] = src_c[k];

    for (genvar j = 0; j < GroupsPerStage; j++) begin : g_group
      localparam int unsigned Lsb = (k * GroupsPerStage + j) * BLOCK;

      cla_group #(
        .BLOCK (BLOCK)
      ) u_group (
        .a    (src_a[k][Lsb +: BLOCK]),
        .b    (src_b[k][Lsb +: BLOCK]),
        .cin  (gc[j]),
        .sum  (slice_sum[k][j*BLOCK +: BLOCK]),
        .gen  (gg[j]),
        .prop (gp[j])
      );

      assign gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end

    assign stage_cout[k] = gc[GroupsPerStage];
  end

  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      s_d[k]                    = src_s[k];
      s_d[k][k*SliceW +: SliceW] = slice_sum[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load[k]) valid_q[k] <= src_valid[k];
      end
    end
  end

  // Datapath is not reset; outputs are gated by out_valid instead.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < int'(STAGES); k++) begin
      if (load[k]) begin
        en_q[k]  <= src_en[k];
        sat_q[k] <= src_sat[k];
        c_q[k]   <= stage_cout[k];
        a_q[k]   <= src_a[k];
        b_q[k]   <= src_b[k];
        s_q[k]   <= s_d[k];
      end
    end
  end

  logic [WIDTH-1:0] final_res;
  logic             c_msb, ovf;

  always_comb begin
    // Carry into the MSB recovered from the MSB sum bit.
    c_msb     = a_q[Last][WIDTH-1] ^ b_q[Last][WIDTH-1] ^ s_q[Last][WIDTH-1];
    ovf       = c_q[Last] ^ c_msb;
    final_res = s_q[Last];
    if (sat_q[Last] && ovf) final_res = a_q[Last][WIDTH-1] ? SMin : SMax;

    out_valid = valid_q[Last];
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    zero      = 1'b0;
    negative  = 1'b0;
    if (valid_q[Last]) begin
      if (en_q[Last]) begin
        result    = final_res;
        overflow  = ovf;
        carry_out = c_q[Last];
        zero      = (final_res == '0);
        negative  = final_res[WIDTH-1];
      end else begin
        zero = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_add_sub.sv
module tb_pipelined_cla_add_sub;

  logic        CLK = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] rs_1, rs_2;
  logic        En, funct7_5, sat_en;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        overflow, carry_out, zero, negative;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  pipelined_cla_add_sub #(
    .WIDTH  (32),
    .BLOCK  (4),
    .STAGES (2)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs_1      (rs_1),
    .rs_2      (rs_2),
    .En        (En),
    .funct7_5  (funct7_5),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .carry_out (carry_out),
    .zero      (zero),
    .negative  (negative)
  );

  // Reference: {result, overflow, carry_out, zero, negative}
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic sat, input logic en);
    logic [32:0] s;
    logic [31:0] r;
    logic        ovf, cout;
    if (!en) return {32'h0, 4'b0010};
    if (sub) begin
      s    = {1'b0, a} - {1'b0, b};
      cout = (a >= b);
    end else begin
      s    = {1'b0, a} + {1'b0, b};
      cout = s[32];
    end
    r   = s[31:0];
    ovf = sub ? (a[31] != b[31] && r[31] != a[31]) : (a[31] == b[31] && r[31] != a[31]);
    if (sat && ovf) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {r, ovf, cout, (r == 32'h0), r[31]};
  endfunction

  // Drives one beat with out_ready high, waits for it, returns what came out.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic sat, input logic en, output logic rdy, output int lat,
                           output logic [31:0] r, output logic [3:0] fl);
    rs_1 = a; rs_2 = b; funct7_5 = sub; sat_en = sat; En = en;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 rdy = in_ready;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge CLK); #1;
      lat++;
    end
    r  = result;
    fl = {overflow, carry_out, zero, negative};
    @(posedge CLK); #1;
  endtask

  task automatic check_beat(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic sat, input logic en,
                            input logic [31:0] exp_r, input logic [3:0] exp_fl);
    logic rdy; int lat; logic [31:0] r; logic [3:0] fl;
    send_beat(a, b, sub, sat, en, rdy, lat, r, fl);
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b want 1", name, rdy);
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL %s_latency: got %0d want 2", name, lat);
    end
    checks++;
    if (r !== exp_r) begin
      errors++; $display("FAIL %s_result: got %h want %h", name, r, exp_r);
    end
    checks++;
    if (fl !== exp_fl) begin
      errors++; $display("FAIL %s_flags(ovf,cout,z,n): got %b want %b", name, fl, exp_fl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rs_1 = '0; rs_2 = '0; En = 1'b0; funct7_5 = 1'b0; sat_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++;
    if ({overflow, carry_out, zero, negative} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {overflow, carry_out, zero, negative});
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_add();
    check_beat("add_5_3", 32'h5, 32'h3, 1'b0, 1'b0, 1'b1, 32'h8, 4'b0000);
    check_beat("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h0, 4'b0110);
    check_beat("add_ovf_nosat", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 4'b1001);
    check_beat("add_ovf_sat", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1000);
  endtask

  task automatic test_sub();
    check_beat("sub_ovf_nosat", 32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b1100);
    check_beat("sub_ovf_sat", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 4'b1101);
    check_beat("sub_zero", 32'h5, 32'h5, 1'b1, 1'b0, 1'b1, 32'h0, 4'b0110);
    check_beat("sub_borrow", 32'h10, 32'h20, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 4'b0001);
  endtask

  task automatic test_en_zero();
    check_beat("en0", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0010);
  endtask

  task automatic test_stall();
    logic [31:0] held;
    rs_1 = 32'd12; rs_2 = 32'd30; funct7_5 = 1'b0; sat_en = 1'b0; En = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd42) begin
      errors++; $display("FAIL stall_first: got valid=%b %h want valid=1 %h", out_valid, result, 32'd42);
    end
    held = 32'd42;
    // Second beat fills stage 0 behind the stalled one.
    rs_1 = 32'd1; rs_2 = 32'd1; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept2: got %b want 1", in_ready); end
    @(posedge CLK); #1;
    in_valid = 1'b1; rs_1 = 32'd9; rs_2 = 32'd9;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full_in_ready: got %b want 0", in_ready); end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== held) begin
      errors++; $display("FAIL stall_hold: got valid=%b %h want valid=1 %h", out_valid, result, held);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd2) begin
      errors++; $display("FAIL stall_second: got valid=%b %h want valid=1 %h", out_valid, result, 32'd2);
    end
    @(posedge CLK); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba [10];
    logic [31:0] bb [10];
    logic        bsub [10];
    logic        bsat [10];
    logic        ben  [10];
    logic [35:0] exp_q [$];
    logic [35:0] exp_v;
    int sent = 0, got = 0, cyc = 0;
    for (int i = 0; i < 10; i++) begin
      ba[i]   = $urandom;
      bb[i]   = $urandom;
      bsub[i] = 1'($urandom_range(1));
      bsat[i] = 1'($urandom_range(1));
      ben[i]  = ($urandom_range(3) != 0);
    end
    while (got < 10 && cyc < 200) begin
      out_ready = (((cyc / 3) % 2) == 0);
      if (sent < 10) begin
        rs_1 = ba[sent]; rs_2 = bb[sent]; funct7_5 = bsub[sent]; sat_en = bsat[sent];
        En = ben[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (in_ready !== !((sent - got) == 2 && !out_ready)) begin
        errors++;
        $display("FAIL b2b_in_ready cyc %0d: got %b with %0d in flight, out_ready=%b",
                 cyc, in_ready, sent - got, out_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_beat: got %h want none", result);
        end else begin
          exp_v = exp_q.pop_front();
          if ({result, overflow, carry_out, zero, negative} !== exp_v) begin
            errors++;
            $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", got, result,
                     {overflow, carry_out, zero, negative}, exp_v[35:4], exp_v[3:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ba[sent], bb[sent], bsub[sent], bsat[sent], ben[sent]));
        sent++;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    checks++;
    if (got != 10) begin errors++; $display("FAIL b2b_count: got %0d beats want 10", got); end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_after: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0; En = 1'b1; funct7_5 = 1'b0; sat_en = 1'b0;
    rs_1 = 32'h11; rs_2 = 32'h22; in_valid = 1'b1;
    @(posedge CLK); #1;
    rs_1 = 32'h33; rs_2 = 32'h44;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge CLK); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    checks++;
    if ({result, overflow, carry_out, zero, negative} !== 36'h0) begin
      errors++; $display("FAIL rstmid_outputs: got %h/%b want 0", result, {overflow, carry_out, zero, negative});
    end
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_discard: got %b want 0", out_valid); end
    check_beat("rstmid_next", 32'd100, 32'd23, 1'b0, 1'b0, 1'b1, 32'd123, 4'b0000);
    check_beat("rstmid_en0", 32'h1234, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_en_zero();
    test_stall();
    test_back_to_back();
    test_reset_midstall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
